// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, funct3,
// FSM states, ALU operations and datapath mux selects.
package rv_mc_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SUBU = 4'd8
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] SRCA_OLDPC = 2'd0;
    localparam logic [1:0] SRCA_PC    = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] RES_TVEC   = 2'd3;

    localparam logic [1:0] RD_RESULT = 2'd0;
    localparam logic [1:0] RD_PC4    = 2'd1;
    localparam logic [1:0] RD_UIMM   = 2'd2;
    localparam logic [1:0] RD_SLT    = 2'd3;

    localparam logic [1:0] TC_ILLEGAL = 2'd0;
    localparam logic [1:0] TC_FETCH   = 2'd1;
    localparam logic [1:0] TC_DATA    = 2'd2;

    function automatic logic is_slt_f3(input logic [2:0] f);
        return f[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/rv_mc_alu_dec.sv
// ALU operation decode; outside the execute phase the ALU always adds
// (PC+4 in fetch, branch/jump target in decode, nothing else matters).
module rv_mc_alu_dec
    import rv_mc_pkg::*;
#(
    parameter int ALU_CTL_W = 4
) (
    input  logic [6:0]           op,
    input  logic [2:0]           f3,
    input  logic [6:0]           f7,
    input  logic                 exec_phase,
    output logic [ALU_CTL_W-1:0] alu_ctl
);

    alu_op_e ctl;
    alu_op_e arith;
    logic    alt;
    logic    unused_f7;

    assign alt       = f7[5];
    assign unused_f7 = ^{f7[6], f7[4:0]};

    // f7[5] selects SUB only for register ops; ADDI carries immediate bits there
    always_comb begin
        arith = ALU_ADD;
        unique case (f3)
            F3_ADD:  arith = (op == OP_REG && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  arith = ALU_SLL;
            F3_SLT:  arith = ALU_SUB;
            F3_SLTU: arith = ALU_SUBU;
            F3_XOR:  arith = ALU_XOR;
            F3_SR:   arith = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   arith = ALU_OR;
            F3_AND:  arith = ALU_AND;
            default: arith = ALU_ADD;
        endcase
    end

    always_comb begin
        ctl = ALU_ADD;
        if (exec_phase) begin
            unique case (op)
                OP_REG, OP_IMM: ctl = arith;
                OP_BRANCH:      ctl = f3[1] ? ALU_SUBU : ALU_SUB;
                default:        ctl = ALU_ADD;
            endcase
        end
    end

    assign alu_ctl = ALU_CTL_W'(ctl);

endmodule

// File: rtl/rv_mc_controller.sv
// Multi-cycle RV32I control FSM with memory handshake timeout and trap state.
// Define RV_MC_PERF_CNT_EN to add the cycle/instret performance counters.
module rv_mc_controller
    import rv_mc_pkg::*;
#(
    parameter int ALU_CTL_W   = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           f3,
    input  logic [6:0]           f7,
    input  logic                 zero,
    input  logic                 sign_bit,
    input  logic                 carry,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic                 reg_write,
    output logic [2:0]           imm_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic [1:0]           result_src,
    output logic [1:0]           reg_data_sel,
    output logic                 trap,
`ifdef RV_MC_PERF_CNT_EN
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt,
`endif
    output logic [1:0]           trap_cause
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_chk
        $error("rv_mc_controller: MEM_TIMEOUT must be >= 2, CNT_W >= 1");
    end

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          cause_q, cause_d;
    logic [ALU_CTL_W-1:0] dec_ctl;

    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_lw, is_sw, is_imm, is_reg, is_slt;
    logic legal, taken, wait_last, timeout;

    assign is_lui   = op == OP_LUI;
    assign is_auipc = op == OP_AUIPC;
    assign is_jal   = op == OP_JAL;
    assign is_jalr  = op == OP_JALR;
    assign is_br    = op == OP_BRANCH;
    assign is_lw    = op == OP_LOAD;
    assign is_sw    = op == OP_STORE;
    assign is_imm   = op == OP_IMM;
    assign is_reg   = op == OP_REG;
    assign is_slt   = (is_reg | is_imm) & is_slt_f3(f3);

    // Branch funct3 010/011 are reserved encodings and trap as illegal
    assign legal = (is_lui | is_auipc | is_jal | is_jalr | is_br |
                    is_lw | is_sw | is_imm | is_reg) &
                   ~(is_br & (f3[2:1] == 2'b01));

    assign wait_last = wait_q == WAIT_LAST;
    assign timeout   = wait_last & ~mem_ready;

    always_comb begin
        taken = 1'b0;
        unique case (f3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = sign_bit;
            F3_BGE:  taken = ~sign_bit;
            F3_BLTU: taken = ~carry;
            F3_BGEU: taken = carry;
            default: taken = 1'b0;
        endcase
    end

    rv_mc_alu_dec #(
        .ALU_CTL_W (ALU_CTL_W)
    ) u_alu_dec (
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .exec_phase (state_q == S_EXEC),
        .alu_ctl    (dec_ctl)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_last) begin
                    state_d = S_TRAP;
                    cause_d = TC_FETCH;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_TRAP;
                    cause_d = TC_ILLEGAL;
                end else if (is_lui) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw | is_sw)               state_d = S_MEM;
                else if (is_br | is_jal | is_jalr) state_d = S_FETCH;
                else                             state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (wait_last) begin
                    state_d = S_TRAP;
                    cause_d = TC_DATA;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
        wait_d = (state_d != state_q) ? '0 : wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cause_q <= TC_ILLEGAL;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_en        = 1'b0;
        reg_write    = 1'b0;
        imm_src      = IMM_I;
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_RS2;
        alu_ctl      = dec_ctl;
        result_src   = RES_ALUOUT;
        reg_data_sel = RD_RESULT;
        trap         = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_en      = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM;
                imm_src   = is_br ? IMM_B : (is_jal ? IMM_J : IMM_I);
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_reg: begin
                        alu_src_a = SRCA_RS1;
                    end
                    is_imm, is_lw: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                    end
                    is_sw: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        imm_src   = IMM_S;
                    end
                    is_auipc: begin
                        alu_src_b = SRCB_IMM;
                        imm_src   = IMM_U;
                    end
                    is_br: begin
                        alu_src_a = SRCA_RS1;
                        pc_en     = taken;
                    end
                    // Target was latched in ALU-out during decode
                    is_jal: begin
                        pc_en        = 1'b1;
                        reg_write    = 1'b1;
                        reg_data_sel = RD_PC4;
                    end
                    is_jalr: begin
                        alu_src_a    = SRCA_RS1;
                        alu_src_b    = SRCB_IMM;
                        result_src   = RES_ALU;
                        pc_en        = 1'b1;
                        reg_write    = 1'b1;
                        reg_data_sel = RD_PC4;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = is_sw & ~timeout;
            end
            S_WB: begin
                reg_write    = 1'b1;
                result_src   = is_lw ? RES_MEM : RES_ALUOUT;
                imm_src      = is_lui ? IMM_U : IMM_I;
                reg_data_sel = is_lui ? RD_UIMM :
                               (is_slt ? RD_SLT : RD_RESULT);
            end
            S_TRAP: begin
                trap       = 1'b1;
                pc_en      = 1'b1;
                result_src = RES_TVEC;
            end
            default: ;
        endcase
        // Held in reset: only the fetch request stays up
        if (!rst) begin
            mem_req      = 1'b1;
            adr_src      = 1'b0;
            mem_write    = 1'b0;
            ir_write     = 1'b0;
            pc_en        = 1'b0;
            reg_write    = 1'b0;
            imm_src      = '0;
            alu_src_a    = '0;
            alu_src_b    = '0;
            alu_ctl      = '0;
            result_src   = '0;
            reg_data_sel = '0;
            trap         = 1'b0;
        end
    end

    assign trap_cause = cause_q;

`ifdef RV_MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, inst_q;
    logic             retire;

    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                    (state_q != S_TRAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (retire) inst_q <= inst_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = inst_q;
`endif

endmodule

// File: doc/rv_mc_controller.md
Name: rv_mc_controller

Overview:
- Next-generation multi-cycle RV32I control unit; drives the shared datapath (PC, IR, register file, ALU, unified memory port).
- Adds a memory ready handshake with timeout, unsigned branches, shifts/AUIPC, and a trap state replacing the dead-end bug state.
- Contains the main FSM plus PC-enable/branch logic and ALU-control decode.

Parameters:
- ALU_CTL_W, 4, width of alu_ctl.
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready before trap (>=2).
- CNT_W, 32, perf counter width (PERF_CNT_EN only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- op  in  7  IR[6:0]
- f3  in  3  IR[14:12]
- f7  in  7  IR[31:25]
- zero  in  1  ALU result==0
- sign_bit  in  1  ALU result[31]
- carry  in  1  ALU subtract carry-out (1 = a>=b unsigned)
- mem_ready  in  1  memory completes the current access
- mem_req  out  1  memory access active
- adr_src  out  1  0=PC, 1=ALU-out address
- mem_write  out  1  store strobe
- ir_write  out  1  IR load
- pc_en  out  1  PC load
- reg_write  out  1  register-file write
- imm_src  out  3  0=I, 1=S, 2=B, 3=J, 4=U
- alu_src_a  out  2  0=oldPC, 1=PC, 2=rs1
- alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
- alu_ctl  out  ALU_CTL_W  ALU op code
- result_src  out  2  0=ALU-out, 1=mem data, 2=ALU result, 3=trap vector
- reg_data_sel  out  2  0=result, 1=PC+4, 2=U-imm, 3=slt bit
- trap  out  1  one-cycle pulse on trap entry
- trap_cause  out  2  0=illegal op, 1=fetch timeout, 2=data timeout; held until next trap

Behaviour:
- Reset (rst=0, async): state=FETCH, wait counter=0, trap_cause=0. All outputs are combinational from state, so reset drives mem_req=1, adr_src=0 and every other output 0.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=2, result_src=2, alu_ctl=ADD.
  - ir_write and pc_en are asserted only in the cycle mem_ready=1; that cycle moves to DECODE.
  - Otherwise stay in FETCH and increment the counter.
- DECODE: alu_src_a=0, alu_src_b=1, imm_src from op (B or J), computes the branch/jump target.
  - Unsupported op, or branch f3 in {010,011} -> TRAP (cause 0).
  - LUI -> WB; all others -> EXEC.
- EXEC:
  - R/I-arith/AUIPC -> WB.
  - LW/SW -> MEM.
  - Branch/JAL/JALR -> FETCH.
  - JAL/JALR: reg_write=1, reg_data_sel=1, pc_en=1.
  - Branch: alu_ctl=SUB; pc_en = taken. beq zero; bne ~zero; blt sign_bit; bge ~sign_bit; bltu ~carry; bgeu carry.
- MEM: mem_req=1, adr_src=1, mem_write=(SW).
  - Hold until mem_ready. Then LW -> WB; SW -> FETCH.
- WB: reg_write=1, one cycle, then FETCH.
  - reg_data_sel: LUI=2, SLT/SLTI/SLTU=3, else 0.
  - result_src: LW=1, else 0.
- Wait counter: cleared on every state entry.
  - In FETCH or MEM, reaching MEM_TIMEOUT-1 with mem_ready=0 -> TRAP (cause 1 or 2); mem_write is deasserted on that transition.
  - mem_ready=1 in the final cycle wins over timeout.
- TRAP: trap=1, pc_en=1, result_src=3, one cycle, then FETCH.
- Latency with mem_ready tied 1:
  - LUI/branch/JAL/JALR: 3 cycles.
  - R/I/AUIPC/SW: 4 cycles.
  - LW: 5 cycles.
- alu_ctl map: R uses f3/f7; I-arith uses f3 (SRAI via f7[5]); LW/SW/JAL/JALR/AUIPC use ADD; SLT*/branch use SUB/SUBU.

Optional Feature:
- Macro RV_MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt and instret_cnt, each CNT_W bits, reset 0, wrapping modulo 2^CNT_W.
  - cycle_cnt increments every cycle.
  - instret_cnt increments on each transition into FETCH from a non-TRAP state.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package rv_mc_pkg: opcode constants, f3 constants, state enum, alu_ctl codes (ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SUBU), imm_src/result_src encodings, trap cause codes.
- One sub-module, rv_mc_alu_dec: combinational (op, f3, f7, exec_phase) -> alu_ctl.
- Branch decode stays inline.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 0, f7 0), mem_ready=1:
  - States F,D,E,WB; reg_write=1 only in WB; alu_ctl=ADD in EXEC; 4 cycles total.
- lw with mem_ready low 3 cycles in MEM:
  - MEM lasts 4 cycles with adr_src=1; then WB with result_src=1.
- bltu, zero=0, carry=0: pc_en=1 in EXEC.
- bltu, carry=1: pc_en=0 in EXEC; next state FETCH.
- Fetch with mem_ready stuck 0 and MEM_TIMEOUT=16:
  - TRAP entered after 16 FETCH cycles; trap pulse=1 with trap_cause=1, result_src=3, pc_en=1; then FETCH.
- op=7'b1111111 in DECODE: TRAP, cause 0, no reg_write or mem_write asserted.
- rst driven low mid-MEM on an SW: mem_write drops immediately (async); FETCH on release.
